// File: rtl/instr_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for instr_loader.
interface instr_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Loads a big-endian byte stream into instruction memory as 32-bit words at 4*k.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader #(
  parameter int unsigned DEPTH = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   word_count,
  instr_loader_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

  state_t      state, state_d;
  logic [31:0] word_idx, word_idx_d;
  logic [31:0] count, count_d;
  logic [1:0]  byte_cnt, byte_cnt_d;
  logic [23:0] shift, shift_d;
  logic        err_d, we_d, ready_d, busy_d, done_d;
  logic [31:0] addr_d, wdata_d;
  logic        accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum, csum_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      word_idx       <= '0;
      count          <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
      error          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      state          <= state_d;
      word_idx       <= word_idx_d;
      count          <= count_d;
      byte_cnt       <= byte_cnt_d;
      shift          <= shift_d;
      error          <= err_d;
      busy           <= busy_d;
      done           <= done_d;
      bus.byte_ready <= ready_d;
      bus.mem_we     <= we_d;
      bus.mem_addr   <= addr_d;
      bus.mem_wdata  <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum           <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    word_idx_d = word_idx;
    count_d    = count;
    byte_cnt_d = byte_cnt;
    shift_d    = shift;
    err_d      = error;
    we_d       = 1'b0;
    addr_d     = bus.mem_addr;
    wdata_d    = bus.mem_wdata;
    accept     = bus.byte_valid && bus.byte_ready;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          count_d    = word_count;
          word_idx_d = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (word_count == 32'd0) begin
            state_d = DONE;
          end else if (word_count > DEPTH) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          shift_d    = {shift[15:0], bus.byte_in};
          byte_cnt_d = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum ^ bus.byte_in;
`endif
          // Fourth byte completes the word; the write issues next cycle
          if (byte_cnt == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = {word_idx[29:0], 2'b00};
            wdata_d = {shift, bus.byte_in};
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx + 32'd1;
        if (word_idx + 32'd1 == count) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          err_d   = (bus.byte_in != csum);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RECV) || (state_d == CHECK);
    busy_d  = (state_d == RECV) || (state_d == WRITE) || (state_d == CHECK);
    done_d  = (state_d == DONE);
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table of loads plus reset and checksum sequences.
module tb_instr_loader;
  localparam int unsigned DEPTH = 1000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  // Cycles from the last write to done (checksum byte adds one cycle)
  localparam int DONE_LAT = CSUM_EN ? 2 : 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] word_count;
  logic        busy, done, error;

  instr_loader_if bus();

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .bus(bus), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] wc;
    logic [3:0]  nb;
    logic [63:0] bytes;
    logic        gap;
    logic        exp_err;
  } vec_t;

  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  last_we_cyc = 0;
  wr_t expq[$];
  wr_t mon_e;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = expq.pop_front();
        check("wr_addr", bus.mem_addr, mon_e.addr);
        check("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  task automatic check_reset_vals(input string name);
    check({name, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({name, "_mem_we"},     32'(bus.mem_we), 32'd0);
    check({name, "_busy"},       32'(busy), 32'd0);
    check({name, "_done"},       32'(done), 32'd0);
    check({name, "_error"},      32'(error), 32'd0);
    check({name, "_mem_addr"},   bus.mem_addr, 32'd0);
    check({name, "_mem_wdata"},  bus.mem_wdata, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input string name);
    int n = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL %s_byte_timeout: got byte_ready=0 for 20 cycles expected 1", name);
    end
    @(posedge clk);
  endtask

  task automatic do_load(input logic [31:0] wc, input int nb, input logic [63:0] bytes,
                         input bit gap, input bit exp_err, input logic [7:0] csum_flip,
                         input string name);
    logic [7:0] b;
    logic [7:0] x;
    wr_t        w;
    int         n;
    int         done_cyc;
    x = 8'h00;
    @(negedge clk);
    start      = 1'b1;
    word_count = wc;
    for (int i = 0; i < nb / 4; i++) begin
      w = {32'(4 * i), bytes[63 - 32 * i -: 32]};
      expq.push_back(w);
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    word_count = 32'hFFFF_FFFF;
    if (nb == 0) begin
      check({name, "_done_t1"},  32'(done), 32'd1);
      check({name, "_error_t1"}, 32'(error), 32'(exp_err));
      check({name, "_busy_t1"},  32'(busy), 32'd0);
    end else begin
      check({name, "_busy_t1"},  32'(busy), 32'd1);
      check({name, "_ready_t1"}, 32'(bus.byte_ready), 32'd1);
      check({name, "_done_t1"},  32'(done), 32'd0);
      for (int i = 0; i < nb; i++) begin
        b = bytes[63 - 8 * i -: 8];
        x = x ^ b;
        send_byte(b, name);
        if (gap && i < nb - 1) begin
          @(negedge clk);
          bus.byte_valid = 1'b0;
        end
      end
      if (CSUM_EN) send_byte(x ^ csum_flip, name);
      @(negedge clk);
      bus.byte_valid = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      done_cyc = cyc;
      check({name, "_done"},     32'(done), 32'd1);
      check({name, "_done_lat"}, 32'(done_cyc - last_we_cyc), 32'(DONE_LAT));
      check({name, "_error"},    32'(error), 32'(exp_err));
      check({name, "_busy_end"}, 32'(busy), 32'd0);
    end
    check({name, "_writes_left"}, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    wr_t w;
    reset          = 1'b1;
    start          = 1'b0;
    word_count     = 32'd0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");

    // Idle with a byte offered: it must not be taken
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_byte_ready", 32'(bus.byte_ready), 32'd0);
      check("idle_mem_we",     32'(bus.mem_we), 32'd0);
    end
    bus.byte_valid = 1'b0;

    vecs[0] = '{wc: 32'd2,    nb: 4'd8, bytes: 64'h8C010004_20020005, gap: 1'b0, exp_err: 1'b0};
    vecs[1] = '{wc: 32'd2,    nb: 4'd8, bytes: 64'h8C010004_20020005, gap: 1'b1, exp_err: 1'b0};
    vecs[2] = '{wc: 32'd0,    nb: 4'd0, bytes: 64'h0,                 gap: 1'b0, exp_err: 1'b0};
    vecs[3] = '{wc: 32'd1001, nb: 4'd0, bytes: 64'h0,                 gap: 1'b0, exp_err: 1'b1};
    vecs[4] = '{wc: 32'd1,    nb: 4'd4, bytes: 64'hDEADBEEF_00000000, gap: 1'b1, exp_err: 1'b0};

    for (int v = 0; v < 5; v++) begin
      do_load(vecs[v].wc, int'(vecs[v].nb), vecs[v].bytes, vecs[v].gap, vecs[v].exp_err,
              8'h00, $sformatf("vec%0d", v));
    end

    // Reset after two words and two bytes of a four-word load
    @(negedge clk);
    start      = 1'b1;
    word_count = 32'd4;
    w = {32'd0, 32'h01020304};
    expq.push_back(w);
    w = {32'd4, 32'h05060708};
    expq.push_back(w);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) send_byte(8'(i), "midreset");
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check("midreset_writes_left", 32'(expq.size()), 32'd0);
    check("midreset_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    do_load(32'd1, 4, 64'hCAFEF00D_00000000, 1'b0, 1'b0, 8'h00, "after_reset");

`ifdef LOADER_CHECKSUM_EN
    do_load(32'd1, 4, 64'h11223344_00000000, 1'b0, 1'b0, 8'h00, "csum_good");
    do_load(32'd1, 4, 64'h11223344_00000000, 1'b0, 1'b1, 8'h01, "csum_bad");
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
